// File: rtl/cpu_controller_if.sv
// Handshake and control bundle between the instruction controller and its
// surroundings: decoded instruction in, datapath controls out.
interface cpu_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       write;
  logic       err;

  modport master (
    output s, opcode, op,
    input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err
  );
endinterface

// File: rtl/cpu_controller.sv
// Moore FSM sequencing the register-file/ALU datapath, one instruction per
// start/wait handshake. Branching uses the opcode/op latched at acceptance.
module cpu_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic              clk,
  input logic              reset,
  cpu_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_GET_A     = 4'd2,
    S_GET_B     = 4'd3,
    S_COMPUTE   = 4'd4,
    S_COMPARE   = 4'd5,
    S_WRITE_REG = 4'd6,
    S_WRITE_IMM = 4'd7,
    S_HALT      = 4'd8
  } state_t;

  state_t     state, nxt;
  logic [2:0] opc_q;
  logic [1:0] op_q;

  logic is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;

  assign is_movi = (opc_q == 3'b110) && (op_q == 2'b10);
  assign is_movr = (opc_q == 3'b110) && (op_q == 2'b00);
  assign is_add  = (opc_q == 3'b101) && (op_q == 2'b00);
  assign is_cmp  = (opc_q == 3'b101) && (op_q == 2'b01);
  assign is_and  = (opc_q == 3'b101) && (op_q == 2'b10);
  assign is_mvn  = (opc_q == 3'b101) && (op_q == 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      opc_q <= 3'b000;
      op_q  <= 2'b00;
    end else begin
      state <= nxt;
      // Latch only on acceptance so later input changes cannot redirect us
      if (state == S_WAIT && bus.s) begin
        opc_q <= bus.opcode;
        op_q  <= bus.op;
      end
    end
  end

  always_comb begin
    nxt       = S_WAIT;
    bus.w     = 1'b0;
    bus.nsel  = 3'b000;
    bus.vsel  = 2'b00;
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
    bus.asel  = 1'b0;
    bus.bsel  = 1'b0;
    bus.write = 1'b0;
    bus.err   = 1'b0;
    case (state)
      S_WAIT: begin
        bus.w = 1'b1;
        nxt   = bus.s ? S_DECODE : S_WAIT;
      end
      S_DECODE: begin
        if (is_movi)                        nxt = S_WRITE_IMM;
        else if (is_movr || is_mvn)         nxt = S_GET_B;
        else if (is_add || is_cmp || is_and) nxt = S_GET_A;
        else if (ILLEGAL_TRAP)              nxt = S_HALT;
        else begin
          bus.err = 1'b1;
          nxt     = S_WAIT;
        end
      end
      S_GET_A: begin
        bus.nsel  = 3'b001;
        bus.loada = 1'b1;
        nxt       = S_GET_B;
      end
      S_GET_B: begin
        bus.nsel  = 3'b010;
        bus.loadb = 1'b1;
        nxt       = is_cmp ? S_COMPARE : S_COMPUTE;
      end
      S_COMPUTE: begin
        // MOV reg passes B through the ALU by zeroing the A operand
        bus.loadc = 1'b1;
        bus.asel  = is_movr;
        nxt       = S_WRITE_REG;
      end
      S_COMPARE: begin
        bus.loads = 1'b1;
        nxt       = S_WAIT;
      end
      S_WRITE_REG: begin
        bus.nsel  = 3'b100;
        bus.write = 1'b1;
        nxt       = S_WAIT;
      end
      S_WRITE_IMM: begin
        bus.nsel  = 3'b001;
        bus.vsel  = 2'b10;
        bus.write = 1'b1;
        nxt       = S_WAIT;
      end
      S_HALT: begin
        bus.err = 1'b1;
        nxt     = S_HALT;
      end
      default: nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed, table-driven bench for cpu_controller: one instance without the
// illegal-opcode trap, one with it.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_controller_if b0 ();
  cpu_controller_if b1 ();

  cpu_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  cpu_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  // {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, err}
  localparam logic [13:0] O_WAIT    = 14'b1_000_00_0_0_0_0_0_0_0_0;
  localparam logic [13:0] O_DEC     = 14'b0_000_00_0_0_0_0_0_0_0_0;
  localparam logic [13:0] O_GETA    = 14'b0_001_00_1_0_0_0_0_0_0_0;
  localparam logic [13:0] O_GETB    = 14'b0_010_00_0_1_0_0_0_0_0_0;
  localparam logic [13:0] O_COMP    = 14'b0_000_00_0_0_1_0_0_0_0_0;
  localparam logic [13:0] O_COMPMOV = 14'b0_000_00_0_0_1_0_1_0_0_0;
  localparam logic [13:0] O_CMPS    = 14'b0_000_00_0_0_0_1_0_0_0_0;
  localparam logic [13:0] O_WREG    = 14'b0_100_00_0_0_0_0_0_0_1_0;
  localparam logic [13:0] O_WIMM    = 14'b0_001_10_0_0_0_0_0_0_1_0;
  localparam logic [13:0] O_ERR     = 14'b0_000_00_0_0_0_0_0_0_0_1;

  logic [13:0] o0, o1;
  assign o0 = {b0.w, b0.nsel, b0.vsel, b0.loada, b0.loadb, b0.loadc, b0.loads,
               b0.asel, b0.bsel, b0.write, b0.err};
  assign o1 = {b1.w, b1.nsel, b1.vsel, b1.loada, b1.loadb, b1.loadc, b1.loads,
               b1.asel, b1.bsel, b1.write, b1.err};

  int checks = 0;
  int errors = 0;
  int wr0    = 0;

  always @(negedge clk) if (b0.write === 1'b1) wr0++;

  typedef struct {
    logic        s;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [13:0] exp;
    string       nm;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic [2:0] opc, input logic [1:0] op,
                     input logic [13:0] exp, input string nm);
    vec_t v;
    v.s = s; v.opc = opc; v.op = op; v.exp = exp; v.nm = nm;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step0(input logic s, input logic [2:0] opc, input logic [1:0] op);
    b0.s = s; b0.opcode = opc; b0.op = op;
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic s, input logic [2:0] opc, input logic [1:0] op);
    b1.s = s; b1.opcode = opc; b1.op = op;
    @(posedge clk); #1;
  endtask

  int wr_base;

  initial begin
    reset = 1'b1;
    b0.s = 1'b0; b0.opcode = 3'b000; b0.op = 2'b00;
    b1.s = 1'b0; b1.opcode = 3'b000; b1.op = 2'b00;

    // ADD, s ignored outside WAIT, MOV imm back-to-back with MOV reg
    add(0, 3'b101, 2'b00, O_WAIT,    "idle_s0");
    add(1, 3'b101, 2'b00, O_DEC,     "add_dec");
    add(0, 3'b000, 2'b00, O_GETA,    "add_geta");
    add(0, 3'b000, 2'b00, O_GETB,    "add_getb");
    add(0, 3'b000, 2'b00, O_COMP,    "add_comp");
    add(0, 3'b000, 2'b00, O_WREG,    "add_wr");
    add(1, 3'b110, 2'b10, O_WAIT,    "add_done_s_ignored");
    add(1, 3'b110, 2'b10, O_DEC,     "movi_dec");
    add(0, 3'b000, 2'b00, O_WIMM,    "movi_wr");
    add(1, 3'b110, 2'b00, O_WAIT,    "movi_done");
    add(1, 3'b110, 2'b00, O_DEC,     "movr_dec_b2b");
    add(0, 3'b000, 2'b00, O_GETB,    "movr_getb");
    add(0, 3'b000, 2'b00, O_COMPMOV, "movr_comp_asel");
    add(0, 3'b000, 2'b00, O_WREG,    "movr_wr");
    add(0, 3'b000, 2'b00, O_WAIT,    "movr_done");
    // CMP: loads only, no loadc/write
    add(1, 3'b101, 2'b01, O_DEC,     "cmp_dec");
    add(0, 3'b000, 2'b00, O_GETA,    "cmp_geta");
    add(0, 3'b000, 2'b00, O_GETB,    "cmp_getb");
    add(0, 3'b000, 2'b00, O_CMPS,    "cmp_loads");
    add(0, 3'b000, 2'b00, O_WAIT,    "cmp_done");
    // MVN skips GET_A
    add(1, 3'b101, 2'b11, O_DEC,     "mvn_dec");
    add(0, 3'b000, 2'b00, O_GETB,    "mvn_getb");
    add(0, 3'b000, 2'b00, O_COMP,    "mvn_comp");
    add(0, 3'b000, 2'b00, O_WREG,    "mvn_wr");
    add(0, 3'b000, 2'b00, O_WAIT,    "mvn_done");
    // AND with inputs switched to MOV imm right after acceptance
    add(1, 3'b101, 2'b10, O_DEC,     "and_dec");
    add(0, 3'b110, 2'b10, O_GETA,    "and_latch_geta");
    add(0, 3'b110, 2'b10, O_GETB,    "and_latch_getb");
    add(0, 3'b110, 2'b10, O_COMP,    "and_comp");
    add(0, 3'b110, 2'b10, O_WREG,    "and_wr");
    add(0, 3'b110, 2'b10, O_WAIT,    "and_done");
    // illegal encodings, no trap
    add(1, 3'b111, 2'b11, O_ERR,     "ill_111_11");
    add(0, 3'b000, 2'b00, O_WAIT,    "ill_111_11_wait");
    add(1, 3'b110, 2'b01, O_ERR,     "ill_110_01");
    add(0, 3'b000, 2'b00, O_WAIT,    "ill_110_01_wait");
    add(1, 3'b100, 2'b00, O_ERR,     "ill_100_00");
    add(0, 3'b000, 2'b00, O_WAIT,    "ill_100_00_wait");

    @(posedge clk); #1;
    chk("reset_dut0", o0, O_WAIT);
    chk("reset_dut1", o1, O_WAIT);
    reset = 1'b0;

    foreach (vq[i]) begin
      step0(vq[i].s, vq[i].opc, vq[i].op);
      chk(vq[i].nm, o0, vq[i].exp);
    end

    // Reset during GET_B of an ADD: immediate WAIT, no write, then normal
    step0(1, 3'b101, 2'b00); chk("rst_add_dec", o0, O_DEC);
    step0(0, 3'b000, 2'b00); chk("rst_add_geta", o0, O_GETA);
    step0(0, 3'b000, 2'b00); chk("rst_add_getb", o0, O_GETB);
    wr_base = wr0;
    #2 reset = 1'b1;
    #1 chk("rst_async", o0, O_WAIT);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_held", o0, O_WAIT);
    step0(0, 3'b000, 2'b00); chk("rst_after", o0, O_WAIT);
    chk_int("rst_no_write", wr0, wr_base);
    step0(1, 3'b110, 2'b10); chk("rst_movi_dec", o0, O_DEC);
    step0(0, 3'b000, 2'b00); chk("rst_movi_wr", o0, O_WIMM);
    step0(0, 3'b000, 2'b00); chk("rst_movi_done", o0, O_WAIT);
    chk_int("rst_movi_one_write", wr0, wr_base + 1);

    // Trapping instance: illegal opcode halts until reset, s ignored
    step1(1, 3'b111, 2'b11); chk("trap_dec", o1, O_DEC);
    step1(1, 3'b110, 2'b10); chk("trap_halt", o1, O_ERR);
    for (int k = 0; k < 3; k++) begin
      step1(1, 3'b101, 2'b00); chk("trap_halt_hold", o1, O_ERR);
    end
    #2 reset = 1'b1;
    #1 chk("trap_reset", o1, O_WAIT);
    @(posedge clk); #1;
    reset = 1'b0;
    step1(1, 3'b110, 2'b10); chk("trap_post_dec", o1, O_DEC);
    step1(0, 3'b000, 2'b00); chk("trap_post_wr", o1, O_WIMM);
    step1(0, 3'b000, 2'b00); chk("trap_post_done", o1, O_WAIT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Moore FSM that sequences the register-file/ALU datapath for one instruction at a time. It sits between the instruction decoder and the datapath. It consumes the decoded opcode/op and drives nsel back into the decoder. It also drives the load enables, the mux selects and the register-file write enable. A start/wait handshake with the top level frames each instruction.

Parameters:
ILLEGAL_TRAP, 0, 0: an unsupported opcode/op pulses err for one cycle and returns to WAIT; 1: enter HALT until reset.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; forces WAIT immediately
s  input  1  start request; sampled only in WAIT
opcode  input  3  decoded instruction[15:13]
op  input  2  decoded instruction[12:11]
w  output  1  idle/ready; high only in WAIT
nsel  output  3  register-index select to decoder, one-hot: 001 Rn, 010 Rm, 100 Rd, 000 none
vsel  output  2  writeback source: 00 ALU result C, 01 PC, 10 sximm8, 11 mdata
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status flags
asel  output  1  1 forces ALU A input to zero
bsel  output  1  1 selects sximm5 as ALU B input
write  output  1  register-file write enable
err  output  1  illegal-instruction indication

Behaviour:
- Outputs are a pure function of state (Moore). Defaults in every state: nsel=000, vsel=00, all enables/selects 0, w=0, err=0.
- On reset assertion: state=WAIT, latched opcode/op=0, w=1, all other outputs 0, regardless of the state in progress. An aborted instruction performs no write after reset.
- Instruction acceptance: in WAIT with s=1 at a rising edge, latch opcode/op into internal registers and go to DECODE. All later branching uses the latched copy, so input changes after acceptance are ignored. If s=0 in WAIT, stay in WAIT. s is ignored in every other state.
- Supported encodings (opcode,op):
  - 110,10 MOV Rn,#imm8
  - 110,00 MOV Rd,Rm{,sh}
  - 101,00 ADD
  - 101,01 CMP
  - 101,10 AND
  - 101,11 MVN
  - Any other encoding is illegal.
- States, asserted outputs and transitions:
  - WAIT: w=1. Next state DECODE if s=1, else WAIT.
  - DECODE: no outputs asserted. MOV imm -> WRITE_IMM. MOV reg or MVN -> GET_B. ADD, CMP or AND -> GET_A. Illegal -> WAIT with err=1 in DECODE when ILLEGAL_TRAP=0, else -> HALT.
  - GET_A: nsel=001, loada=1. Next state GET_B.
  - GET_B: nsel=010, loadb=1. CMP -> COMPARE; otherwise -> COMPUTE.
  - COMPUTE: loadc=1, bsel=0. asel=1 for MOV reg, else asel=0. Next state WRITE_REG.
  - COMPARE: loads=1, asel=0, bsel=0, loadc=0. Next state WAIT.
  - WRITE_REG: nsel=100, vsel=00, write=1. Next state WAIT.
  - WRITE_IMM: nsel=001, vsel=10, write=1. Next state WAIT.
  - HALT: err=1, w=0. Stays in HALT until reset.
- Latency, counted in cycles from the accepting edge until w is high again:
  - MOV imm: 2 (DECODE, WRITE_IMM)
  - MOV reg: 4
  - MVN: 4
  - CMP: 4
  - ADD/AND: 5
- Exactly one write pulse per non-CMP legal instruction. CMP produces no write and no loadc.
- MVN does not load A; the datapath ignores A for MVN.
- Back-to-back operation: if s=1 in the WAIT cycle entered after completion, the next instruction is accepted on that edge. There are no idle bubbles beyond the single WAIT cycle.
- Unreachable state encodings recover to WAIT on the next edge.

Test Plan:
- Reset mid-instruction: accept ADD (101,00), assert reset during GET_B -> w=1 in the same cycle (async), no write pulse, then the next s is accepted normally.
- MOV imm: s=1 with 110,10 -> DECODE then WRITE_IMM with nsel=001, vsel=10, write=1 for exactly one cycle; w=1 two cycles after acceptance.
- ADD: 101,00 -> loada with nsel=001, then loadb with nsel=010, then loadc with asel=0, then write with nsel=100, vsel=00; w returns after 5 cycles.
- CMP and MOV reg: 101,01 -> loads=1 once, write and loadc never asserted, w after 4 cycles. 110,00 -> loada never asserted, asel=1 during loadc, write with nsel=100.
- Latch check: accept AND (101,10), then change opcode to 110 and op to 10 in the next cycle -> the full AND sequence still runs (GET_A present, 5 cycles).
- Illegal 111,11: ILLEGAL_TRAP=0 -> err=1 for one cycle, back in WAIT after 1 cycle. ILLEGAL_TRAP=1 -> err held high and w=0 until reset, s ignored.
